// File: rtl/bali_lib_pkg.sv
// Shared arbitration types and the generic one-hot to binary encoder.
package bali_lib_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // OR-reduction encoder; callers zero-extend their one-hot vector and truncate the result.
  function automatic logic [4:0] onehot_enc32(input logic [31:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bali_rr_arb_if.sv
// Request/grant bundle between requesters (master side) and the round-robin arbiter (slave side).
interface bali_rr_arb_if #(
  parameter int N_REQ = 8
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0] req;
  logic             gnt_ack;
  logic             gnt_vld;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;

  modport master (output req, gnt_ack, input gnt_vld, gnt, gnt_idx);
  modport slave  (input req, gnt_ack, output gnt_vld, gnt, gnt_idx);
endinterface

// File: rtl/bali_rr_pick.sv
// Combinational rotating-priority pick: lowest set request at or above ptr, else lowest overall.
module bali_rr_pick #(
  parameter int N_REQ = 8
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         pick_o,
  output logic                     any_o
);
  logic [N_REQ-1:0]   mask;
  logic [2*N_REQ-1:0] dbl;
  logic [2*N_REQ-1:0] lsb;

  assign mask = ~((N_REQ'(1) << ptr_i) - N_REQ'(1));

  // Masked copy in the low half wins; the unmasked copy in the high half is the wrap-around fallback.
  assign dbl    = {req_i, req_i & mask};
  assign lsb    = dbl & (~dbl + (2*N_REQ)'(1));
  assign pick_o = lsb[N_REQ-1:0] | lsb[2*N_REQ-1:N_REQ];
  assign any_o  = |req_i;
endmodule

// File: rtl/bali_rr_arb.sv
// Round-robin arbiter with sticky registered grants and back-to-back re-arbitration on ack.
module bali_rr_arb
  import bali_lib_pkg::*;
#(
  parameter int N_REQ = 8
) (
  input logic          clk,
  input logic          rst,
  bali_rr_arb_if.slave bus
);
  localparam int IDX_W = $clog2(N_REQ);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [IDX_W-1:0] ptr_nxt;
  logic [IDX_W-1:0] pick_ptr;
  logic [N_REQ-1:0] pick;
  logic [IDX_W-1:0] pick_idx;
  logic             any_req;
  logic             ack_take;

  assign ack_take = (state_q == ST_GRANT) && bus.gnt_ack;
  assign ptr_nxt  = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
  // On ack the pick already runs from the post-ack pointer, so the acked requester ranks last.
  assign pick_ptr = ack_take ? ptr_nxt : ptr_q;

  bali_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i  (bus.req),
    .ptr_i  (pick_ptr),
    .pick_o (pick),
    .any_o  (any_req)
  );

  assign pick_idx = IDX_W'(onehot_enc32(32'(pick)));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_GRANT;
          gnt_d   = pick;
          idx_d   = pick_idx;
        end
      end
      ST_GRANT: begin
        if (bus.gnt_ack) begin
          ptr_d = ptr_nxt;
          if (any_req) begin
            gnt_d = pick;
            idx_d = pick_idx;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            idx_d   = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.gnt_vld = (state_q == ST_GRANT);
  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = idx_q;
endmodule

// File: tb/tb_bali_rr_arb.sv
// Bench for bali_rr_arb: directed vector table at N_REQ=8 plus randomised sweeps at N_REQ=2, 5, 32.
module tb_bali_rr_arb;

  typedef struct {
    logic [7:0] req;
    logic       ack;
    logic       vld;
    logic [7:0] gnt;
    int         idx;
  } vec_t;

  typedef struct {
    logic        vld;
    logic [31:0] gnt;
    int          idx;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit done_sw [3];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference pick: plain cyclic scan starting at ptr.
  function automatic void model_pick(input logic [31:0] req, input int ptr, input int n,
                                     output int p, output bit any);
    any = 1'b0;
    p   = 0;
    for (int k = 0; k < n; k++) begin
      int j;
      j = (ptr + k) % n;
      if (!any && req[j]) begin
        any = 1'b1;
        p   = j;
      end
    end
  endfunction

  function automatic void model_step(input int n, input logic [31:0] req, input bit ack,
                                     inout bit vld, inout int idx, inout int ptr);
    int p;
    bit any;
    if (!vld) begin
      model_pick(req, ptr, n, p, any);
      if (any) begin
        vld = 1'b1;
        idx = p;
      end
    end else if (ack) begin
      ptr = (idx + 1) % n;
      model_pick(req, ptr, n, p, any);
      if (any) idx = p;
      else begin
        vld = 1'b0;
        idx = 0;
      end
    end
  endfunction

  // ---------------- directed N_REQ=8 instance ----------------
  logic rst;
  bali_rr_arb_if #(.N_REQ(8)) b8 ();
  bali_rr_arb #(.N_REQ(8)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));

  vec_t tbl[$];
  exp_t sb8[$];

  function automatic void add(input logic [7:0] r, input logic a, input logic v,
                              input logic [7:0] g, input int i);
    vec_t t;
    t.req = r; t.ack = a; t.vld = v; t.gnt = g; t.idx = i;
    tbl.push_back(t);
  endfunction

  task automatic apply_vec(input vec_t v, input int row);
    exp_t e;
    @(negedge clk);
    b8.req     = v.req;
    b8.gnt_ack = v.ack;
    e.vld = v.vld; e.gnt = 32'(v.gnt); e.idx = v.idx;
    sb8.push_back(e);
    @(posedge clk);
    #1;
    e = sb8.pop_front();
    check($sformatf("row%0d_vld", row), 32'(b8.gnt_vld), 32'(e.vld));
    check($sformatf("row%0d_gnt", row), 32'(b8.gnt), e.gnt);
    check($sformatf("row%0d_idx", row), 32'(b8.gnt_idx), e.idx);
  endtask

  initial begin
    vec_t v0;
    rst        = 1'b1;
    b8.req     = '0;
    b8.gnt_ack = 1'b0;

    add(8'hFF, 0, 1, 8'h01, 0);
    for (int k = 1; k <= 9; k++) add(8'hFF, 1, 1, 8'(1 << (k % 8)), k % 8);
    add(8'h10, 1, 1, 8'h10, 4);
    add(8'h00, 0, 1, 8'h10, 4);
    add(8'h00, 1, 0, 8'h00, 0);
    add(8'h10, 0, 1, 8'h10, 4);
    add(8'h00, 1, 0, 8'h00, 0);
    add(8'h40, 0, 1, 8'h40, 6);
    add(8'h41, 1, 1, 8'h01, 0);
    add(8'h41, 1, 1, 8'h40, 6);
    add(8'h00, 1, 0, 8'h00, 0);
    add(8'h04, 0, 1, 8'h04, 2);
    for (int k = 0; k < 5; k++) add(8'h00, 0, 1, 8'h04, 2);
    add(8'h00, 1, 0, 8'h00, 0);
    add(8'h00, 1, 0, 8'h00, 0);
    add(8'h09, 0, 1, 8'h08, 3);
    add(8'h09, 1, 1, 8'h01, 0);
    add(8'h09, 1, 1, 8'h08, 3);
    add(8'hFF, 1, 1, 8'h10, 4);
    add(8'h00, 1, 0, 8'h00, 0);

    repeat (2) @(posedge clk);
    #1;
    check("rst_vld", 32'(b8.gnt_vld), 0);
    check("rst_gnt", 32'(b8.gnt), 0);
    check("rst_idx", 32'(b8.gnt_idx), 0);
    @(negedge clk);
    rst = 1'b0;

    v0.req = 8'hFF; v0.ack = 1'b0; v0.vld = 1'b1; v0.gnt = 8'h01; v0.idx = 0;
    apply_vec(v0, -1);
    // Advance the pointer so the post-reset grant really depends on the reset.
    v0.ack = 1'b1; v0.gnt = 8'h02; v0.idx = 1;
    apply_vec(v0, -2);

    @(negedge clk);
    b8.gnt_ack = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_vld", 32'(b8.gnt_vld), 0);
    check("midrst_gnt", 32'(b8.gnt), 0);
    check("midrst_idx", 32'(b8.gnt_idx), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < tbl.size(); r++) apply_vec(tbl[r], r);

    for (int c = 0; c < 5000; c++) begin
      if (done_sw[0] && done_sw[1] && done_sw[2]) break;
      @(posedge clk);
    end
    check("sweeps_done", 32'(done_sw[0] && done_sw[1] && done_sw[2]), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // ---------------- randomised sweeps ----------------
  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int N = (g == 0) ? 2 : ((g == 1) ? 5 : 32);

    logic rst_s;
    bali_rr_arb_if #(.N_REQ(N)) bs ();
    bali_rr_arb #(.N_REQ(N)) dut (.clk(clk), .rst(rst_s), .bus(bs.slave));

    exp_t        q[$];
    exp_t        e;
    bit          m_vld;
    int          m_idx;
    int          m_ptr;
    logic [31:0] r;
    logic [31:0] msk;
    bit          a;
    bit          dprev;
    int          waitc[32];
    int          worst;

    initial begin
      rst_s      = 1'b1;
      bs.req     = '0;
      bs.gnt_ack = 1'b0;
      m_vld = 1'b0; m_idx = 0; m_ptr = 0;
      msk   = (N == 32) ? 32'hFFFF_FFFF : ((32'd1 << N) - 32'd1);
      for (int i = 0; i < 32; i++) waitc[i] = 0;
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("sw%0d_rst_vld", N), 32'(bs.gnt_vld), 0);
      @(negedge clk);
      rst_s = 1'b0;

      for (int cyc = 0; cyc < 400; cyc++) begin
        @(negedge clk);
        r = $urandom;
        if ($urandom_range(0, 3) == 0) r = r & $urandom;
        if ($urandom_range(0, 7) == 0) r = '0;
        r = r & msk;
        a = ($urandom_range(0, 9) < 7);
        dprev      = bs.gnt_vld;
        bs.req     = r[N-1:0];
        bs.gnt_ack = a;
        model_step(N, r, a, m_vld, m_idx, m_ptr);
        e.vld = m_vld;
        e.gnt = m_vld ? (32'd1 << m_idx) : 32'd0;
        e.idx = m_idx;
        q.push_back(e);

        @(posedge clk);
        #1;
        e = q.pop_front();
        check($sformatf("sw%0d_vld", N), 32'(bs.gnt_vld), 32'(e.vld));
        check($sformatf("sw%0d_gnt", N), 32'(bs.gnt), e.gnt);
        check($sformatf("sw%0d_idx", N), 32'(bs.gnt_idx), e.idx);
        check($sformatf("sw%0d_onehot", N),
              32'($countones(bs.gnt) == (bs.gnt_vld ? 1 : 0)), 1);
        if (bs.gnt_vld) check($sformatf("sw%0d_gnt_at_idx", N), 32'(bs.gnt[bs.gnt_idx]), 1);

        if (bs.gnt_vld && (!dprev || a)) begin
          worst = 0;
          for (int i = 0; i < N; i++) begin
            if (r[i] && (i != int'(bs.gnt_idx))) waitc[i]++;
            else waitc[i] = 0;
            if (waitc[i] > worst) worst = waitc[i];
          end
          check($sformatf("sw%0d_starve", N), 32'(worst <= N), 1);
        end
      end
      done_sw[g] = 1'b1;
    end
  end

endmodule
